// File: rtl/aes_decrypt_core.sv
// ---------------------------------------------------------------------------
// aes_decrypt_core -- iterative AES inverse cipher, one round per clock.
//
// Contents of this file (self-contained):
//   aes_dec_pkg   : GF(2^8) helpers and forward/inverse S-box functions.
//   shift_rows    : (Inv)ShiftRows on a 128-bit state, INVERSE selects.
//   sub_bytes     : (Inv)SubBytes on a 128-bit state, INVERSE selects.
//   mix_columns   : (Inv)MixColumns on a 128-bit state, INVERSE selects.
//   aes_decrypt_core : the FSM + datapath (top).
//
// Top ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : ciphertext on in_data is valid
//   in_ready   : core accepts a block this cycle (only in IDLE)
//   in_data    : ciphertext, byte 0 in [127:120], column-major
//   rk_idx     : round-key index requested from the external key store
//   rk_data    : round key for rk_idx, combinational from the key store
//   out_valid  : plaintext on out_data is valid (only in DONE)
//   out_ready  : consumer accepts out_data
//   out_data   : plaintext, same byte order as in_data
//   abort      : (only with AES_DEC_ABORT_EN) drop the block in flight
//   dbg_state  : current FSM state (IDLE=0, ROUND=1, DONE=2)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Neither valid depends combinationally on the matching ready.
//
// Optional feature: define AES_DEC_ABORT_EN to add the abort input.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package aes_dec_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = a;
    res = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Inverse affine transform first, then the field inverse.
  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

endpackage

// ---------------------------------------------------------------------------
// shift_rows: state byte n = row (n % 4), column (n / 4).
// Forward shifts row r left by r; inverse shifts it right by r.
// ---------------------------------------------------------------------------
module shift_rows #(
  parameter bit INVERSE = 1'b0
) (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SRC_C = INVERSE ? ((c + 4 - r) % 4) : ((c + r) % 4);
      assign data_o[127-8*(r+4*c) -: 8] = data_i[127-8*(r+4*SRC_C) -: 8];
    end
  end
endmodule

// ---------------------------------------------------------------------------
// sub_bytes: byte-wise S-box (forward) or inverse S-box.
// ---------------------------------------------------------------------------
module sub_bytes #(
  parameter bit INVERSE = 1'b0
) (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  import aes_dec_pkg::*;
  for (genvar i = 0; i < 16; i++) begin : g_byte
    if (INVERSE) begin : g_inv
      assign data_o[127-8*i -: 8] = sbox_inv(data_i[127-8*i -: 8]);
    end else begin : g_fwd
      assign data_o[127-8*i -: 8] = sbox_fwd(data_i[127-8*i -: 8]);
    end
  end
endmodule

// ---------------------------------------------------------------------------
// mix_columns: per-column matrix multiply over GF(2^8).
// Forward rows {2,3,1,1}; inverse rows {e,b,d,9}, each rotated per output.
// ---------------------------------------------------------------------------
module mix_columns #(
  parameter bit INVERSE = 1'b0
) (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  import aes_dec_pkg::*;
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = data_i[127-32*c    -: 8];
    assign a1 = data_i[127-32*c-8  -: 8];
    assign a2 = data_i[127-32*c-16 -: 8];
    assign a3 = data_i[127-32*c-24 -: 8];
    if (INVERSE) begin : g_inv
      assign data_o[127-32*c    -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                                      ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      assign data_o[127-32*c-8  -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                                      ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      assign data_o[127-32*c-16 -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                                      ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      assign data_o[127-32*c-24 -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                                      ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end else begin : g_fwd
      assign data_o[127-32*c    -: 8] = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
      assign data_o[127-32*c-8  -: 8] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
      assign data_o[127-32*c-16 -: 8] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
      assign data_o[127-32*c-24 -: 8] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
    end
  end
endmodule

// ---------------------------------------------------------------------------
// aes_decrypt_core: top-level FSM.
//   IDLE : in_ready=1, rk_idx=NUM_ROUNDS. Handshake loads
//          state = in_data ^ rk[NUM_ROUNDS], counter = NUM_ROUNDS-1.
//   ROUND: rk_idx = counter. state <= InvMixColumns(InvSubBytes(
//          InvShiftRows(state)) ^ rk[counter]); on counter 0 the
//          InvMixColumns is skipped and the result lands in out_data.
//   DONE : out_valid=1 until out_ready, then back to IDLE. The return to
//          IDLE costs one cycle, so no acceptance can coincide with the
//          output handshake.
// Counting the handshake cycle as cycle 0, out_valid appears in cycle
// NUM_ROUNDS+1 (the cycles in between show rk_idx NUM_ROUNDS-1 .. 0).
// ---------------------------------------------------------------------------
module aes_decrypt_core #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
`ifdef AES_DEC_ABORT_EN
  input  logic         abort,
`endif
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] LAST_IDX  = 4'(NUM_ROUNDS);
  localparam logic [3:0] FIRST_CNT = 4'(NUM_ROUNDS - 1);

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   out_q, out_d;

  logic [127:0]   isr_out;
  logic [127:0]   isb_out;
  logic [127:0]   ark_out;
  logic [127:0]   imc_out;

  // One inverse round of datapath, always computed from the state register.
  shift_rows  #(.INVERSE(1'b1)) u_isr (.data_i(data_q),  .data_o(isr_out));
  sub_bytes   #(.INVERSE(1'b1)) u_isb (.data_i(isr_out), .data_o(isb_out));
  assign ark_out = isb_out ^ rk_data;
  mix_columns #(.INVERSE(1'b1)) u_imc (.data_i(ark_out), .data_o(imc_out));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      data_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data ^ rk_data;
          cnt_d   = FIRST_CNT;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (cnt_q == 4'd0) begin
          out_d   = ark_out;
          state_d = DONE;
        end else begin
          data_d  = imc_out;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef AES_DEC_ABORT_EN
    // Abort wins over everything except being already idle.
    if (abort && (state_q != IDLE)) state_d = IDLE;
`endif
  end

  // Outputs depend on registered state only; rk_idx has no input path.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign rk_idx    = (state_q == ROUND) ? cnt_q : LAST_IDX;
  assign out_data  = out_q;
  assign dbg_state = state_q;

endmodule

// File: doc/aes_decrypt_core.md
AES_DECRYPT_CORE -- requirements
Module: aes_decrypt_core

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 10, giving the number of cipher rounds (AES-128).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: ciphertext on in_data is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the core accepts a block this cycle.
REQ-006 The block SHALL have port in_data, input, 128 bits: ciphertext, with byte 0 in [127:120] and FIPS-197 column-major order.
REQ-007 The block SHALL have port rk_idx, output, 4 bits: index of the round key requested this cycle.
REQ-008 The block SHALL have port rk_data, input, 128 bits: round key for rk_idx, supplied combinationally the same cycle by an external key store.
REQ-009 The block SHALL have port out_valid, output, 1 bit: plaintext on out_data is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-011 The block SHALL have port out_data, output, 128 bits: plaintext, same byte order as in_data.

Function
REQ-012 The block SHALL implement the FSM states IDLE, ROUND and DONE.
REQ-013 In IDLE the block SHALL assert in_ready=1 and drive rk_idx=NUM_ROUNDS.
REQ-014 On an in_valid&&in_ready handshake the block SHALL load state = in_data XOR rk_data, set round counter = NUM_ROUNDS-1 and go to ROUND.
REQ-015 In ROUND, per cycle, rk_idx SHALL equal the counter, and state SHALL become InvShiftRows, then InvSubBytes, then XOR rk_data, then InvMixColumns, with the counter decrementing.
REQ-016 When the counter is 0, InvMixColumns SHALL be skipped, the result registered into out_data, and the FSM SHALL go to DONE.
REQ-017 The block SHALL reuse the team's shift_rows, sub_bytes and mix_columns modules with INVERSE=1.
REQ-018 out_valid SHALL rise exactly NUM_ROUNDS+1 cycles after the accepting edge, i.e. 11 cycles for the default.
REQ-019 In DONE the block SHALL hold out_valid=1 and keep out_data stable until out_valid&&out_ready, then return to IDLE.
REQ-020 in_ready SHALL be 0 in ROUND and DONE, and in_valid SHALL be ignored there.
REQ-021 The block SHALL NOT accept a new block in the same cycle as the output handshake; the next acceptance SHALL be no earlier than the following cycle.
REQ-022 out_data SHALL hold its last value outside DONE, and only out_valid qualifies it.
REQ-023 rk_idx SHALL be a pure function of the FSM state and the counter, with no combinational path from any input.

Reset
REQ-024 While rst_n=0 the block SHALL force state IDLE, round counter 0, internal state register 0, out_data=0, out_valid=0, in_ready=1 and rk_idx=NUM_ROUNDS.
REQ-025 An assertion of rst_n mid-ROUND or mid-DONE SHALL discard the block in flight, with no out_valid pulse after release.
REQ-026 The block SHALL accept the first handshake on the first rising edge after rst_n deasserts.

Configuration
REQ-027 With macro AES_DEC_ABORT_EN defined, the block SHALL add input abort (1 bit); abort=1 in ROUND or DONE SHALL return the block to IDLE next cycle with out_valid=0, and SHALL be ignored in IDLE.
REQ-028 With AES_DEC_ABORT_EN undefined, the abort port SHALL NOT exist and behaviour SHALL be as in REQ-012..REQ-023.

Verification
REQ-029 The bench SHALL cover the FIPS-197 C.1 vector: ct 69c4e0d86a7b0430d8cdb78070b4c55a with key-store key 000102030405060708090a0b0c0d0e0f -> out_data 00112233445566778899aabbccddeeff, out_valid 11 cycles after acceptance.
REQ-030 The bench SHALL cover rk_idx during decryption: sampled each cycle from acceptance, the sequence SHALL be 10,9,8,...,0.
REQ-031 The bench SHALL cover back-pressure: out_ready=0 for 5 cycles -> out_valid stays 1, out_data is stable and in_ready=0; on out_ready=1, IDLE next cycle.
REQ-032 The bench SHALL cover back-to-back operation: two blocks with in_valid held high -> second acceptance one cycle after the first output handshake, and both plaintexts correct.
REQ-033 The bench SHALL cover reset mid-round: rst_n=0 at round 5 -> outputs at reset values immediately, and no out_valid for 20 cycles after release with in_valid=0.
REQ-034 The bench SHALL cover abort with AES_DEC_ABORT_EN defined: abort at round 3 -> IDLE and in_ready=1 next cycle, and no out_valid.
